// File: rtl/spi_pkg.sv
// Shared SPI master definitions: mode encodings, CPOL/CPHA helpers and FSM states.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period divider, sclk register, edge counter and
// leading/trailing strobes that fire in the cycle sclk is driven to the new level.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter logic        CPOL    = 1'b0,
  parameter int unsigned BITS    = 8,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned DIV_W  = $clog2(CLK_DIV),
  localparam int unsigned EDGE_W = $clog2(2 * BITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              toggle_en,
  output logic              tick_c,
  output logic              lead_stb_c,
  output logic              trail_stb_c,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              sclk
);

  logic [DIV_W-1:0] div;

  assign tick_c      = run && (div == DIV_W'(CLK_DIV - 1));
  assign lead_stb_c  = tick_c && toggle_en && !edge_cnt[0];
  assign trail_stb_c = tick_c && toggle_en && edge_cnt[0];

  // Even edge indices are leading edges, odd ones trailing; 2*BITS toggles return sclk to CPOL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div      <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL;
    end else begin
      if (!run || tick_c) div <= '0;
      else                div <= div + DIV_W'(1);

      if (!run) begin
        edge_cnt <= '0;
      end else if (lead_stb_c || trail_stb_c) begin
        edge_cnt <= (edge_cnt == EDGE_W'(2 * BITS - 1)) ? '0 : edge_cnt + EDGE_W'(1);
        sclk     <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// Full-duplex SPI master, one BITS-wide frame per start, all four modes.
// SPI_LSB_FIRST_EN selects LSB-first shifting; default is MSB-first.
module spi_master_core
  import spi_pkg::*;
#(
  parameter logic [1:0]  MODE    = SPI_MODE0,
  parameter int unsigned BITS    = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [BITS-1:0] tx_data,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] rx_data,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            ss_n
);

  localparam logic        CPOL      = mode_cpol(MODE);
  localparam logic        CPHA      = mode_cpha(MODE);
  localparam int unsigned EDGE_W    = $clog2(2 * BITS);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * BITS - 1);

  spi_state_e        state, state_next;
  logic [BITS-1:0]   tx_sr, rx_sr, tx_next, rx_next;
  logic [EDGE_W-1:0] edge_cnt;
  logic              tick_c, lead_stb_c, trail_stb_c;
  logic              run_c, xfer_c;
  logic              load_c, advance_c, capture_c, finish_c;

  assign run_c  = (state != ST_IDLE);
  assign xfer_c = (state == ST_XFER);

  spi_sclk_gen #(
    .CPOL    (CPOL),
    .BITS    (BITS),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run_c),
    .toggle_en   (xfer_c),
    .tick_c      (tick_c),
    .lead_stb_c  (lead_stb_c),
    .trail_stb_c (trail_stb_c),
    .edge_cnt    (edge_cnt),
    .sclk        (sclk)
  );

  // mosi comes straight from the shift register flop; clearing it at frame end idles mosi low.
`ifdef SPI_LSB_FIRST_EN
  assign mosi    = tx_sr[0];
  assign tx_next = {1'b0, tx_sr[BITS-1:1]};
  assign rx_next = {miso, rx_sr[BITS-1:1]};
`else
  assign mosi    = tx_sr[BITS-1];
  assign tx_next = {tx_sr[BITS-2:0], 1'b0};
  assign rx_next = {rx_sr[BITS-2:0], miso};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // The first bit is already on mosi before any edge, so one edge per frame never advances.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    advance_c  = 1'b0;
    capture_c  = 1'b0;
    finish_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETUP;
          load_c     = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick_c) state_next = ST_XFER;
      end
      ST_XFER: begin
        if (CPHA) begin
          capture_c = trail_stb_c;
          advance_c = lead_stb_c && (edge_cnt != '0);
        end else begin
          capture_c = lead_stb_c;
          advance_c = trail_stb_c && (edge_cnt != LAST_EDGE);
        end
        if (trail_stb_c && (edge_cnt == LAST_EDGE)) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick_c) begin
          state_next = ST_IDLE;
          finish_c   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ss_n    <= 1'b1;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
    end else begin
      done <= finish_c;
      if (load_c) begin
        busy  <= 1'b1;
        ss_n  <= 1'b0;
        tx_sr <= tx_data;
      end else if (finish_c) begin
        busy    <= 1'b0;
        ss_n    <= 1'b1;
        tx_sr   <= '0;
        rx_data <= rx_sr;
      end else if (advance_c) begin
        tx_sr <= tx_next;
      end
      if (capture_c) rx_sr <= rx_next;
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: one DUT per SPI mode, each against a cycle-sampled slave model.
`timescale 1ns/1ps
module tb_spi_master_core;

  localparam int unsigned BITS      = 8;
  localparam int unsigned CLK_DIV   = 4;
  localparam int          NM        = 4;
  localparam int          FRAME_CYC = 1 + CLK_DIV * (2 * BITS + 2);

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NM-1:0]   start = '0;
  logic [NM-1:0]   busy, done, sclk, mosi, miso, ss_n;
  logic [BITS-1:0] tx_data [NM];
  logic [BITS-1:0] rx_data [NM];

  int checks = 0;
  int errors = 0;

  // Slave model and monitor state
  logic [NM-1:0]   loop_en = '0;
  logic [NM-1:0]   s_miso  = '0;
  logic [NM-1:0]   sclk_q  = 4'b1100;
  logic [NM-1:0]   ss_n_q  = '1;
  logic            mon_lead;
  logic [BITS-1:0] sdin [NM];
  logic [BITS-1:0] s_rx [NM];
  int s_idx [NM];
  int s_scnt [NM];
  int ss_low_cnt [NM];
  int edge_seen [NM];
  int done_cnt [NM];
  int mosi_hi_cnt [NM];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_dut
    spi_master_core #(
      .MODE    (2'(g)),
      .BITS    (BITS),
      .CLK_DIV (CLK_DIV)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start[g]),
      .tx_data (tx_data[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .rx_data (rx_data[g]),
      .sclk    (sclk[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g]),
      .ss_n    (ss_n[g])
    );
  end

  assign miso = (loop_en & mosi) | (~loop_en & s_miso);

  function automatic logic cpol_of(input int m);
    return logic'((m >> 1) & 1);
  endfunction

  function automatic logic cpha_of(input int m);
    return logic'(m & 1);
  endfunction

  // Word position of the idx-th bit on the wire
  function automatic int bit_pos(input int idx);
`ifdef SPI_LSB_FIRST_EN
    return idx;
`else
    return int'(BITS) - 1 - idx;
`endif
  endfunction

  // Slave: sees sclk/ss_n one half clk late, drives on its shift edge, samples on the other.
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (!ss_n[i]) begin
        ss_low_cnt[i]++;
        if (mosi[i]) mosi_hi_cnt[i]++;
      end
      if (done[i]) done_cnt[i]++;
      if (ss_n_q[i] && !ss_n[i]) begin
        s_idx[i]  = 0;
        s_scnt[i] = 0;
        s_rx[i]   = '0;
        if (cpha_of(i) == 1'b0) begin
          s_miso[i] = sdin[i][bit_pos(0)];
          s_idx[i]  = 1;
        end
      end else if (!ss_n[i] && (sclk[i] != sclk_q[i])) begin
        edge_seen[i]++;
        mon_lead = (sclk_q[i] == cpol_of(i));
        if (mon_lead == !cpha_of(i)) begin
          if (s_scnt[i] < int'(BITS)) s_rx[i][bit_pos(s_scnt[i])] = mosi[i];
          s_scnt[i]++;
        end else begin
          if (s_idx[i] < int'(BITS)) s_miso[i] = sdin[i][bit_pos(s_idx[i])];
          s_idx[i]++;
        end
      end
      sclk_q[i] = sclk[i];
      ss_n_q[i] = ss_n[i];
    end
  end

  task automatic start_frame(input int m, input logic [BITS-1:0] tx);
    @(posedge clk); #1;
    start[m]   = 1'b1;
    tx_data[m] = tx;
    @(posedge clk); #1;
    start[m]   = 1'b0;
    tx_data[m] = BITS'($urandom);
  endtask

  // lat counts cycles from the start cycle to the done cycle; grows past the bound on timeout
  task automatic wait_done(input int m, output int lat);
    lat = 1;
    while (!done[m] && lat <= 4 * FRAME_CYC) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = '0;
    for (int i = 0; i < NM; i++) begin
      tx_data[i] = '0;
      sdin[i]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) begin
      checks++; if (ss_n[i] !== 1'b1) begin errors++; $display("FAIL reset_ss_n[%0d]: got %b want 1", i, ss_n[i]); end
      checks++; if (sclk[i] !== cpol_of(i)) begin errors++; $display("FAIL reset_sclk[%0d]: got %b want %b", i, sclk[i], cpol_of(i)); end
      checks++; if (mosi[i] !== 1'b0) begin errors++; $display("FAIL reset_mosi[%0d]: got %b want 0", i, mosi[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]); end
      checks++; if (done[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", i, done[i]); end
      checks++; if (rx_data[i] !== '0) begin errors++; $display("FAIL reset_rx[%0d]: got %h want 00", i, rx_data[i]); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_loopback();
    int lat, s0, e0, d0;
    logic [BITS-1:0] tx;
    tx = 8'hA5;
    loop_en[0] = 1'b1;
    s0 = ss_low_cnt[0]; e0 = edge_seen[0]; d0 = done_cnt[0];
    start_frame(0, tx);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b want 1", busy[0]); end
    checks++; if (ss_n[0] !== 1'b0) begin errors++; $display("FAIL loop_ss_n_low: got %b want 0", ss_n[0]); end
    checks++; if (mosi[0] !== tx[bit_pos(0)]) begin errors++; $display("FAIL loop_first_bit: got %b want %b", mosi[0], tx[bit_pos(0)]); end
    wait_done(0, lat);
    checks++; if (lat != FRAME_CYC) begin errors++; $display("FAIL loop_latency: got %0d want %0d", lat, FRAME_CYC); end
    checks++; if (rx_data[0] !== tx) begin errors++; $display("FAIL loop_rx: got %h want %h", rx_data[0], tx); end
    checks++; if (busy[0] !== 1'b0 || ss_n[0] !== 1'b1) begin errors++; $display("FAIL loop_end: busy %b ss_n %b want 0 1", busy[0], ss_n[0]); end
    checks++; if (mosi[0] !== 1'b0 || sclk[0] !== 1'b0) begin errors++; $display("FAIL loop_idle_pins: mosi %b sclk %b want 0 0", mosi[0], sclk[0]); end
    @(negedge clk); #1;
    checks++; if (ss_low_cnt[0] - s0 != FRAME_CYC - 1) begin errors++; $display("FAIL loop_ss_low: got %0d want %0d", ss_low_cnt[0] - s0, FRAME_CYC - 1); end
    checks++; if (edge_seen[0] - e0 != 2 * BITS) begin errors++; $display("FAIL loop_edges: got %0d want %0d", edge_seen[0] - e0, 2 * BITS); end
    checks++; if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL loop_done_pulses: got %0d want 1", done_cnt[0] - d0); end
    loop_en[0] = 1'b0;
  endtask

  task automatic test_bit_order();
    int lat, h0;
    logic [BITS-1:0] tx;
    tx = '0;
    tx[bit_pos(0)] = 1'b1;
    loop_en[0] = 1'b1;
    h0 = mosi_hi_cnt[0];
    start_frame(0, tx);
    checks++; if (mosi[0] !== 1'b1) begin errors++; $display("FAIL order_first_bit: got %b want 1", mosi[0]); end
    wait_done(0, lat);
    checks++; if (rx_data[0] !== tx) begin errors++; $display("FAIL order_rx: got %h want %h", rx_data[0], tx); end
    @(negedge clk); #1;
    // mode 0: first bit lasts from ss_n fall to the first trailing edge
    checks++; if (mosi_hi_cnt[0] - h0 != 3 * CLK_DIV) begin errors++; $display("FAIL order_mosi_high: got %0d want %0d", mosi_hi_cnt[0] - h0, 3 * CLK_DIV); end
    loop_en[0] = 1'b0;
  endtask

  task automatic test_mode11();
    int lat;
    sdin[3] = 8'h3C;
    start_frame(3, 8'hC3);
    wait_done(3, lat);
    checks++; if (lat != FRAME_CYC) begin errors++; $display("FAIL m11_latency: got %0d want %0d", lat, FRAME_CYC); end
    checks++; if (rx_data[3] !== 8'h3C) begin errors++; $display("FAIL m11_master_rx: got %h want 3c", rx_data[3]); end
    checks++; if (s_rx[3] !== 8'hC3) begin errors++; $display("FAIL m11_slave_rx: got %h want c3", s_rx[3]); end
    checks++; if (sclk[3] !== 1'b1) begin errors++; $display("FAIL m11_sclk_idle: got %b want 1", sclk[3]); end
  endtask

  task automatic test_mode_sweep();
    int lat;
    logic [BITS-1:0] w, s;
    for (int m = 0; m < NM; m++) begin
      for (int k = 0; k < 3; k++) begin
        w = BITS'($urandom);
        s = BITS'($urandom);
        sdin[m] = s;
        start_frame(m, w);
        wait_done(m, lat);
        checks++; if (lat != FRAME_CYC) begin errors++; $display("FAIL sweep_latency m%0d: got %0d want %0d", m, lat, FRAME_CYC); end
        checks++; if (rx_data[m] !== s) begin errors++; $display("FAIL sweep_master_rx m%0d: got %h want %h", m, rx_data[m], s); end
        checks++; if (s_rx[m] !== w) begin errors++; $display("FAIL sweep_slave_rx m%0d: got %h want %h", m, s_rx[m], w); end
        checks++; if (sclk[m] !== cpol_of(m)) begin errors++; $display("FAIL sweep_sclk_idle m%0d: got %b want %b", m, sclk[m], cpol_of(m)); end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, d0;
    logic [BITS-1:0] w, s;
    w = BITS'($urandom_range(0, 254));
    s = BITS'($urandom);
    sdin[0] = s;
    d0 = done_cnt[0];
    start_frame(0, w);
    repeat (30) @(posedge clk);
    start_frame(0, 8'hFF);
    wait_done(0, lat);
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL busy_done_seen: got %b want 1", done[0]); end
    checks++; if (s_rx[0] !== w) begin errors++; $display("FAIL busy_slave_rx: got %h want %h", s_rx[0], w); end
    checks++; if (rx_data[0] !== s) begin errors++; $display("FAIL busy_master_rx: got %h want %h", rx_data[0], s); end
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    checks++; if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt[0] - d0); end
    checks++; if (busy[0] !== 1'b0 || ss_n[0] !== 1'b1) begin errors++; $display("FAIL busy_idle_after: busy %b ss_n %b want 0 1", busy[0], ss_n[0]); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, e0, n;
    logic [BITS-1:0] w, s;
    e0 = edge_seen[1];
    start_frame(1, BITS'($urandom));
    n = 0;
    while ((edge_seen[1] - e0 < 5) && (n < 4 * FRAME_CYC)) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (edge_seen[1] - e0 < 5) begin errors++; $display("FAIL rst_mid_reach_edge5: got %0d want 5", edge_seen[1] - e0); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (ss_n[1] !== 1'b1) begin errors++; $display("FAIL rst_mid_ss_n: got %b want 1", ss_n[1]); end
    checks++; if (sclk[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", sclk[1]); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy[1]); end
    checks++; if (mosi[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_mosi: got %b want 0", mosi[1]); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    w = BITS'($urandom);
    s = BITS'($urandom);
    sdin[1] = s;
    start_frame(1, w);
    wait_done(1, lat);
    checks++; if (lat != FRAME_CYC) begin errors++; $display("FAIL rst_mid_clean_latency: got %0d want %0d", lat, FRAME_CYC); end
    checks++; if (rx_data[1] !== s) begin errors++; $display("FAIL rst_mid_clean_rx: got %h want %h", rx_data[1], s); end
    checks++; if (s_rx[1] !== w) begin errors++; $display("FAIL rst_mid_clean_slave: got %h want %h", s_rx[1], w); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [BITS-1:0] w1, w2, s1, s2;
    w1 = BITS'($urandom); w2 = BITS'($urandom);
    s1 = BITS'($urandom); s2 = BITS'($urandom);
    sdin[2] = s1;
    start_frame(2, w1);
    wait_done(2, lat);
    checks++; if (rx_data[2] !== s1) begin errors++; $display("FAIL b2b_rx1: got %h want %h", rx_data[2], s1); end
    checks++; if (s_rx[2] !== w1) begin errors++; $display("FAIL b2b_slave1: got %h want %h", s_rx[2], w1); end
    sdin[2] = s2;
    start_frame(2, w2);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", busy[2]); end
    wait_done(2, lat);
    checks++; if (lat != FRAME_CYC) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, FRAME_CYC); end
    checks++; if (rx_data[2] !== s2) begin errors++; $display("FAIL b2b_rx2: got %h want %h", rx_data[2], s2); end
    checks++; if (s_rx[2] !== w2) begin errors++; $display("FAIL b2b_slave2: got %h want %h", s_rx[2], w2); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_bit_order();
    test_mode11();
    test_mode_sweep();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
